fwd_hazard_unit: RTL
====================

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 The block SHALL provide parameter AW, default 5, meaning register-address width.
REQ-002 The block SHALL provide parameter LOAD_STALL, default 1, legal 1..7, meaning bubble cycles inserted per load-use hazard.
REQ-003 The block SHALL provide parameter CNT_W, default 16, meaning stall-counter width.
REQ-004 The block SHALL use one clock, clk, and a synchronous active-high reset, reset; both are 1-bit inputs.
REQ-005 The block SHALL have these ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- fwd_en  in  1  1 = forwarding mode; 0 = stall-only mode.
- IFID_src1, IFID_src2  in  AW  source registers of the instruction in ID.
- IDEX_src1, IDEX_src2  in  AW  source registers of the instruction in EX.
- IDEX_MemRead, IDEX_RegWrite  in  1  controls of the instruction in EX.
- IDEX_dest  in  AW  destination of the instruction in EX.
- EXMEM_RegWrite  in  1  EX/MEM write enable.
- EXMEM_dest  in  AW  EX/MEM destination.
- MEMWB_RegWrite  in  1  MEM/WB write enable.
- MEMWB_dest  in  AW  MEM/WB destination.
- fwdA, fwdB  out  2  ALU operand select: 0 = register file, 1 = EX/MEM, 2 = MEM/WB.
- stall  out  1  hold PC and IF/ID.
- IDEX_flush  out  1  insert a bubble into ID/EX.
- stall_count  out  CNT_W  total stall cycles since reset.

Function
REQ-006 fwdA/fwdB SHALL be combinational. With fwd_en=1 the select SHALL be 1 when EXMEM_RegWrite=1, EXMEM_dest!=0 and EXMEM_dest equals the operand's IDEX source.
REQ-007 Otherwise, with fwd_en=1, the select SHALL be 2 when MEMWB_RegWrite=1, MEMWB_dest!=0 and MEMWB_dest equals the operand's IDEX source; in all other cases it SHALL be 0.
REQ-008 When both EX/MEM and MEM/WB match the same operand, EX/MEM SHALL win; register 0 SHALL never be forwarded.
REQ-009 With fwd_en=0, fwdA and fwdB SHALL both be 0.
REQ-010 A load-use hit SHALL be defined as IDEX_MemRead=1, IDEX_dest!=0, and IDEX_dest equal to IFID_src1 or IFID_src2.
REQ-011 A raw hit SHALL be defined as: any of the ID/EX, EX/MEM or MEM/WB stages has RegWrite=1 with a nonzero destination equal to IFID_src1 or IFID_src2.
REQ-012 The FSM SHALL have states IDLE and HOLD, plus a 3-bit down-counter cnt.
REQ-013 In IDLE with fwd_en=1, stall SHALL equal the load-use hit, combinationally, in the same cycle.
REQ-014 In IDLE with fwd_en=1, on a load-use hit with LOAD_STALL>1, the next state SHALL be HOLD and cnt SHALL load LOAD_STALL-1; with LOAD_STALL=1 the state SHALL remain IDLE.
REQ-015 In IDLE with fwd_en=0, stall SHALL equal the raw hit, combinationally, and the state SHALL remain IDLE.
REQ-016 In HOLD, stall SHALL be 1 unconditionally, independent of hit inputs and fwd_en, and cnt SHALL decrement each cycle.
REQ-017 HOLD SHALL return to IDLE in the cycle after cnt=1, so each load-use hazard produces exactly LOAD_STALL consecutive stall cycles.
REQ-018 A hit evaluated on the first IDLE cycle after HOLD SHALL be honoured as a new hazard.
REQ-019 A change of fwd_en during HOLD SHALL NOT shorten or extend the HOLD sequence; the new mode SHALL apply from the next IDLE cycle.
REQ-020 IDEX_flush SHALL equal stall in every cycle.
REQ-021 stall_count SHALL increment by 1 on each rising edge where stall=1 and reset=0, and SHALL saturate at 2^CNT_W-1 without wrapping.

Reset
REQ-022 On a clock edge with reset=1, the state SHALL become IDLE, cnt SHALL become 0 and stall_count SHALL become 0; reset SHALL take priority over all other events, including mid-HOLD.
REQ-023 During reset, stall and IDEX_flush SHALL follow the combinational IDLE rules, and fwdA/fwdB SHALL remain purely combinational.

Verification
REQ-024 EX/MEM priority: fwd_en=1, EXMEM_RegWrite=1, EXMEM_dest=5, MEMWB_RegWrite=1, MEMWB_dest=5, IDEX_src1=5, IDEX_src2=3 -> fwdA=1, fwdB=0; then set EXMEM_dest=0 -> fwdA=2.
REQ-025 Load-use with LOAD_STALL=3: IDEX_MemRead=1, IDEX_dest=7, IFID_src2=7 for one cycle, then bubble inputs -> stall=1 for exactly 3 cycles, and stall_count increases 0 -> 3.
REQ-026 Stall-only mode: fwd_en=0, MEMWB_RegWrite=1, MEMWB_dest=9, IFID_src1=9, IDEX_src1=9 -> fwdA=0 and stall=1; set MEMWB_RegWrite=0 -> stall=0.
REQ-027 Reset mid-HOLD: LOAD_STALL=4, reset asserted on the 2nd stall cycle -> the next cycle is IDLE with stall=0 (no hit) and stall_count=0.
REQ-028 Counter saturation: CNT_W=4, hold the raw hit with fwd_en=0 for 20 cycles -> stall_count stops at 15.
REQ-029 Register 0 is never a hazard: IDEX_MemRead=1, IDEX_dest=0, IFID_src1=0 -> stall=0; EXMEM_dest=0 with IDEX_src1=0 -> fwdA=0.

Source files
------------

// File: rtl/fwd_hazard_unit_if.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit_if
//
// Purpose:
//   Bundles the pipeline-register fields that the forwarding / hazard unit
//   observes, together with the forwarding selects, stall controls and stall
//   counter that it produces.
//
// Parameters:
//   AW     register-address width
//   CNT_W  stall-counter width
//
// Signals (direction as seen by the hazard unit, i.e. the slave modport):
//   fwd_en                  in   1 = forwarding mode, 0 = stall-only mode
//   IFID_src1/IFID_src2     in   source registers of the instruction in ID
//   IDEX_src1/IDEX_src2     in   source registers of the instruction in EX
//   IDEX_MemRead            in   instruction in EX is a load
//   IDEX_RegWrite           in   instruction in EX writes a register
//   IDEX_dest               in   destination of the instruction in EX
//   EXMEM_RegWrite/_dest    in   EX/MEM write enable and destination
//   MEMWB_RegWrite/_dest    in   MEM/WB write enable and destination
//   fwdA/fwdB               out  ALU operand select (0 regfile, 1 EX/MEM, 2 MEM/WB)
//   stall                   out  hold PC and IF/ID
//   IDEX_flush              out  insert a bubble into ID/EX
//   stall_count             out  saturating count of stall cycles since reset
// -----------------------------------------------------------------------------
`default_nettype none

interface fwd_hazard_unit_if #(
    parameter int AW    = 5,
    parameter int CNT_W = 16
);
    logic             fwd_en;
    logic [AW-1:0]    IFID_src1;
    logic [AW-1:0]    IFID_src2;
    logic [AW-1:0]    IDEX_src1;
    logic [AW-1:0]    IDEX_src2;
    logic             IDEX_MemRead;
    logic             IDEX_RegWrite;
    logic [AW-1:0]    IDEX_dest;
    logic             EXMEM_RegWrite;
    logic [AW-1:0]    EXMEM_dest;
    logic             MEMWB_RegWrite;
    logic [AW-1:0]    MEMWB_dest;

    logic [1:0]       fwdA;
    logic [1:0]       fwdB;
    logic             stall;
    logic             IDEX_flush;
    logic [CNT_W-1:0] stall_count;

    // Pipeline side: drives the stage fields, consumes the hazard decisions.
    modport master (
        output fwd_en,
        output IFID_src1, IFID_src2,
        output IDEX_src1, IDEX_src2,
        output IDEX_MemRead, IDEX_RegWrite, IDEX_dest,
        output EXMEM_RegWrite, EXMEM_dest,
        output MEMWB_RegWrite, MEMWB_dest,
        input  fwdA, fwdB, stall, IDEX_flush, stall_count
    );

    // Hazard unit side.
    modport slave (
        input  fwd_en,
        input  IFID_src1, IFID_src2,
        input  IDEX_src1, IDEX_src2,
        input  IDEX_MemRead, IDEX_RegWrite, IDEX_dest,
        input  EXMEM_RegWrite, EXMEM_dest,
        input  MEMWB_RegWrite, MEMWB_dest,
        output fwdA, fwdB, stall, IDEX_flush, stall_count
    );
endinterface

`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//
// Purpose:
//   Data-hazard control for a classic 5-stage pipeline.
//   * Forwarding mode (fwd_en=1): produces ALU operand selects for the
//     instruction in EX (EX/MEM beats MEM/WB, r0 never forwarded) and stalls
//     only on a load-use hazard. Each load-use hazard yields exactly
//     LOAD_STALL consecutive stall cycles; the first is combinational from
//     the hit, the remaining LOAD_STALL-1 come from the HOLD state.
//   * Stall-only mode (fwd_en=0): forwarding is disabled and ID stalls for
//     as long as any in-flight writer (ID/EX, EX/MEM, MEM/WB) targets one of
//     its nonzero source registers.
//   A saturating counter records the total number of stall cycles.
//
// Parameters:
//   AW          register-address width
//   LOAD_STALL  bubble cycles per load-use hazard, legal 1..7
//   CNT_W       stall-counter width
//
// Ports:
//   clk    in  clock
//   reset  in  synchronous active-high reset
//   bus    fwd_hazard_unit_if.slave  stage fields in, hazard decisions out
// -----------------------------------------------------------------------------
`default_nettype none

module fwd_hazard_unit #(
    parameter int AW         = 5,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    fwd_hazard_unit_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Operand-select encoding driven on fwdA/fwdB.
    localparam logic [1:0] SEL_REG   = 2'd0;
    localparam logic [1:0] SEL_EXMEM = 2'd1;
    localparam logic [1:0] SEL_MEMWB = 2'd2;

    // HOLD covers the stall cycles after the first one.
    localparam logic [2:0] HOLD_INIT = 3'(LOAD_STALL - 1);

    state_e           state_q;
    logic [2:0]       cnt_q;
    logic [CNT_W-1:0] stall_count_q;
    logic [CNT_W-1:0] stall_count_d;

    logic exmem_wr_valid;
    logic memwb_wr_valid;
    logic idex_wr_valid;
    logic load_use_hit;
    logic raw_hit;
    logic idle_stall;
    logic stall_int;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    // -------------------------------------------------------------------------
    // Hit detection. A writer only counts if it really writes a nonzero
    // register; r0 is hardwired to zero so it can never carry a dependency.
    // -------------------------------------------------------------------------
    assign exmem_wr_valid = bus.EXMEM_RegWrite && (bus.EXMEM_dest != '0);
    assign memwb_wr_valid = bus.MEMWB_RegWrite && (bus.MEMWB_dest != '0);
    assign idex_wr_valid  = bus.IDEX_RegWrite  && (bus.IDEX_dest  != '0);

    assign load_use_hit = bus.IDEX_MemRead && (bus.IDEX_dest != '0) &&
                          ((bus.IDEX_dest == bus.IFID_src1) ||
                           (bus.IDEX_dest == bus.IFID_src2));

    assign raw_hit =
        (idex_wr_valid  && ((bus.IDEX_dest  == bus.IFID_src1) || (bus.IDEX_dest  == bus.IFID_src2))) ||
        (exmem_wr_valid && ((bus.EXMEM_dest == bus.IFID_src1) || (bus.EXMEM_dest == bus.IFID_src2))) ||
        (memwb_wr_valid && ((bus.MEMWB_dest == bus.IFID_src1) || (bus.MEMWB_dest == bus.IFID_src2)));

    // -------------------------------------------------------------------------
    // Forwarding selects. EX/MEM is checked first because it holds the
    // younger, and therefore correct, value when both stages match.
    // -------------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default on the first
    // line, so no path through the block can leave it unassigned and infer a
    // latch.
    always_comb begin
        fwd_a = SEL_REG;
        fwd_b = SEL_REG;
        if (bus.fwd_en) begin
            if (exmem_wr_valid && (bus.EXMEM_dest == bus.IDEX_src1)) begin
                fwd_a = SEL_EXMEM;
            end else if (memwb_wr_valid && (bus.MEMWB_dest == bus.IDEX_src1)) begin
                fwd_a = SEL_MEMWB;
            end

            if (exmem_wr_valid && (bus.EXMEM_dest == bus.IDEX_src2)) begin
                fwd_b = SEL_EXMEM;
            end else if (memwb_wr_valid && (bus.MEMWB_dest == bus.IDEX_src2)) begin
                fwd_b = SEL_MEMWB;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stall. In IDLE the stall is a pure function of the current hit so the
    // first bubble lands in the same cycle as the hazard. While reset is high
    // the registered state is about to be discarded, so the IDLE rule applies
    // even if state_q still says HOLD.
    // -------------------------------------------------------------------------
    always_comb begin
        idle_stall = bus.fwd_en ? load_use_hit : raw_hit;
        stall_int  = idle_stall;
        if (!reset && (state_q == HOLD)) begin
            stall_int = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Load-use sequencer. fwd_en is only looked at on the IDLE exit decision,
    // so toggling it mid-HOLD cannot change the length of the sequence.
    // -------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.fwd_en && load_use_hit && (LOAD_STALL > 1)) begin
                        state_q <= HOLD;
                        cnt_q   <= HOLD_INIT;
                    end
                end
                HOLD: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Stall-cycle counter, saturating at all-ones.
    // -------------------------------------------------------------------------
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_int && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.fwdA        = fwd_a;
    assign bus.fwdB        = fwd_b;
    assign bus.stall       = stall_int;
    assign bus.IDEX_flush  = stall_int;
    assign bus.stall_count = stall_count_q;

endmodule

`default_nettype wire
